led_status_ctrl: RTL and testbench
==================================

// Module: led_status_ctrl
// PURPOSE
//  Multi-channel status-LED driver; successor to the fixed single-LED blink counter in the board tops.
//  One shared prescaler produces a tick at TICK_HZ. Each channel independently runs one of four modes:
//   - OFF, ON, BLINK at a runtime-programmable half-period, or
//   - ACTIVITY: pulse-stretches one-cycle events, e.g. MAC good-frame or MDIO status strobes.
//  Sits in the board top between the MAC/MDIO status signals and the led pins.
// PARAMETERS
//  CHANNELS      4           number of independent LED channels (1..32)
//  CLK_HZ        125000000   clk_i frequency in Hz
//  TICK_HZ       1000        prescaler tick rate; DIV = CLK_HZ/TICK_HZ, must be >= 2
//  PERIOD_W      16          width of each per-channel half-period field, in ticks
//  STRETCH_TICKS 50          ACTIVITY on-time after the last event, in ticks (>= 1)
// PORTS
//  clk_i          in   1                  system clock
//  rst_n_i        in   1                  asynchronous active-low reset
//  mode_i         in   2*CHANNELS         per-channel mode; ch n uses [2n+1:2n]: 00 OFF, 01 ON, 10 BLINK, 11 ACTIVITY
//  half_period_i  in   PERIOD_W*CHANNELS  per-channel BLINK half-period in ticks; ch n uses [PERIOD_W*n +: PERIOD_W]
//  event_i        in   CHANNELS           per-channel activity strobe; any high cycle counts, level is re-triggering
//  led_o          out  CHANNELS           registered LED drive, 1 = lit
//  tick_o         out  1                  one-cycle prescaler tick pulse
// BEHAVIOUR
//  Reset (rst_n_i low, async)
//   - led_o = 0, tick_o = 0, prescaler = 0.
//   - Every channel: blink cnt = 0, phase = 0, stretch = 0, mode_q = OFF.
//   - Reset release must be externally synchronised (rst_gen output).
//  Prescaler
//   - Counts 0..DIV-1 and wraps.
//   - tick_o = 1 for exactly the cycle after the counter equals DIV-1, i.e. registered, one tick every DIV cycles.
//   - First tick_o occurs DIV cycles after reset release.
//  Per channel: mode_q registers mode_i. A change is detected when mode_i != mode_q.
//   - OFF: led_o <= 0. cnt, phase and stretch are held at 0.
//   - ON: led_o <= 1. cnt, phase and stretch are held at 0.
//   - BLINK, on mode change into BLINK: cnt <= 0, phase <= 1, so the LED lights on the next cycle.
//   - BLINK, on tick_o: if cnt >= hp-1 then cnt <= 0 and phase toggles; else cnt <= cnt+1.
//     hp = half_period_i, with a value of 0 treated as 1. led_o <= phase.
//   - BLINK, live period change: half_period_i is not latched; it takes effect at the next tick compare.
//     If the current cnt already exceeds the new hp-1, the channel toggles on that next tick.
//   - ACTIVITY, when event_i = 1 in any cycle: stretch <= STRETCH_TICKS.
//   - ACTIVITY, else on tick_o with stretch != 0: stretch <= stretch-1.
//   - ACTIVITY: led_o <= (stretch != 0) | event_i.
//   - ACTIVITY: an event in the same cycle as a tick reloads; load wins over decrement.
//   - ACTIVITY: stretch saturates at STRETCH_TICKS and never wraps below 0.
//   - ACTIVITY, on mode change into ACTIVITY: stretch <= 0.
//   - Outside ACTIVITY, event_i is ignored.
//  Latency: led_o reflects mode_i/event_i one clk_i after sampling. No combinational input-to-output path.
//  Width rules
//   - Prescaler width = $clog2(DIV); stretch width = $clog2(STRETCH_TICKS+1).
//   - cnt is PERIOD_W bits; the compare uses PERIOD_W-bit unsigned arithmetic. hp = 2^PERIOD_W-1 is legal.
//  Channels are fully independent. Two channels in BLINK with equal hp entered on the same cycle stay phase-locked.
//  Async reset mid-blink or mid-stretch: all state is cleared immediately; led_o = 0 with no glitch to 1.
// TESTING (sim params: CLK_HZ=1000, TICK_HZ=100 -> DIV=10; CHANNELS=4; PERIOD_W=8; STRETCH_TICKS=3)
//  1. Release reset; hold mode_i OFF.
//     -> led_o = 0; tick_o pulses at cycles 10, 20, 30..., each pulse 1 cycle wide.
//  2. ch0 mode -> BLINK with hp=2.
//     -> led_o[0] goes 1 the next cycle, then toggles on every 2nd tick: 20-cycle high/low periods, 40-cycle period.
//  3. ch1 BLINK with hp=0.
//     -> behaves as hp=1: led_o[1] toggles on every tick.
//     Then change hp 5 -> 1 while cnt=3 -> ch1 toggles on the next tick.
//  4. ch2 ACTIVITY; single event_i[2] pulse just after a tick.
//     -> led_o[2] goes 1 the next cycle and stays 1 for 3 ticks, then 0.
//     A second pulse 1 tick later extends the on-time to 3 ticks after the second pulse.
//  5. ch3 ACTIVITY; event_i[3] asserted in the same cycle as tick_o, with stretch=1.
//     -> stretch reloads to 3, no decrement. Also drive event_i[3] in OFF mode -> led_o[3] stays 0.
//  6. Mid-blink on all channels with ch2 stretching, assert rst_n_i asynchronously between edges.
//     -> led_o = 0 and tick_o = 0 immediately.
//     After release, the first tick arrives at 10 cycles and ch0 BLINK restarts with phase 1.

Source files
------------

// File: rtl/led_status_ctrl.sv
// rtl/led_status_ctrl.sv - multi-channel status LED driver with shared tick prescaler
module led_status_ctrl #(
    parameter int CHANNELS      = 4,
    parameter int CLK_HZ        = 125000000,
    parameter int TICK_HZ       = 1000,
    parameter int PERIOD_W      = 16,
    parameter int STRETCH_TICKS = 50
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [2*CHANNELS-1:0]        mode_i,
    input  logic [PERIOD_W*CHANNELS-1:0] half_period_i,
    input  logic [CHANNELS-1:0]          event_i,
    output logic [CHANNELS-1:0]          led_o,
    output logic                         tick_o
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ST_W = $clog2(STRETCH_TICKS + 1);

    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(DIV - 1);
    localparam logic [ST_W-1:0]     ST_LOAD = ST_W'(STRETCH_TICKS);
    localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);
    localparam logic [ST_W-1:0]     S_ONE   = ST_W'(1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_ACT   = 2'b11;

    logic [PS_W-1:0]     ps_cnt;
    logic [CHANNELS-1:0] led_d;

    // Shared prescaler: tick is registered, high the cycle after the counter reaches DIV-1
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ps_cnt <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= (ps_cnt == PS_LAST);
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
        end
    end

    // LED pins are registered from each channel's next-state drive
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            led_o <= '0;
        end else begin
            led_o <= led_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]          mode_n;
        logic [1:0]          mode_q;
        logic [PERIOD_W-1:0] hp;
        logic [PERIOD_W-1:0] hp_m1;
        logic                ev;
        logic                changed;
        logic [PERIOD_W-1:0] cnt_q;
        logic [PERIOD_W-1:0] cnt_d;
        logic                phase_q;
        logic                phase_d;
        logic [ST_W-1:0]     str_q;
        logic [ST_W-1:0]     str_d;

        assign mode_n  = mode_i[2*g +: 2];
        assign hp      = half_period_i[PERIOD_W*g +: PERIOD_W];
        assign ev      = event_i[g];
        assign changed = (mode_n != mode_q);
        // A zero half-period behaves as one tick; the period is read live, never latched
        assign hp_m1   = (hp == '0) ? '0 : hp - P_ONE;

        // Per-channel next-state and LED drive selected by the requested mode
        always_comb begin
            cnt_d    = '0;
            phase_d  = 1'b0;
            str_d    = '0;
            led_d[g] = 1'b0;
            case (mode_n)
                MODE_ON: begin
                    led_d[g] = 1'b1;
                end
                MODE_BLINK: begin
                    cnt_d   = cnt_q;
                    phase_d = phase_q;
                    if (changed) begin
                        cnt_d   = '0;
                        phase_d = 1'b1;
                    end else if (tick_o) begin
                        if (cnt_q >= hp_m1) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + P_ONE;
                        end
                    end
                    led_d[g] = phase_d;
                end
                MODE_ACT: begin
                    str_d = str_q;
                    if (ev) begin
                        str_d = ST_LOAD;
                    end else if (changed) begin
                        str_d = '0;
                    end else if (tick_o && (str_q != '0)) begin
                        str_d = str_q - S_ONE;
                    end
                    led_d[g] = (str_d != '0) | ev;
                end
                default: begin
                    led_d[g] = 1'b0;
                end
            endcase
        end

        // Per-channel state registers
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                mode_q  <= MODE_OFF;
                cnt_q   <= '0;
                phase_q <= 1'b0;
                str_q   <= '0;
            end else begin
                mode_q  <= mode_n;
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
                str_q   <= str_d;
            end
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb/tb_led_status_ctrl.sv - scoreboard bench for led_status_ctrl
module tb_led_status_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mode = '0;
    logic [31:0] hp = '0;
    logic [3:0]  ev = '0;
    logic [3:0]  led;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] led;
        logic       chk_tick;
        logic       tick;
        string      name;
    } exp_t;

    exp_t sb[$];

    led_status_ctrl #(
        .CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .PERIOD_W(8), .STRETCH_TICKS(3)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .half_period_i(hp),
        .event_i(ev), .led_o(led), .tick_o(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void expect_at(int c, logic [3:0] m, logic [3:0] l, logic ct, logic t, string n);
        exp_t e;
        e.cyc = c; e.mask = m; e.led = l; e.chk_tick = ct; e.tick = t; e.name = n;
        sb.push_back(e);
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checks++;
                    if (((led & sb[i].mask) !== (sb[i].led & sb[i].mask)) ||
                        (sb[i].chk_tick && (tick !== sb[i].tick))) begin
                        errors++;
                        $display("FAIL %s cyc=%0d led=%b tick=%b required led=%b mask=%b tick=%b",
                                 sb[i].name, cyc, led, tick, sb[i].led, sb[i].mask, sb[i].tick);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic check_now(string n, logic [3:0] l, logic t);
        checks++;
        if (led !== l || tick !== t) begin
            errors++;
            $display("FAIL %s led=%b tick=%b required led=%b tick=%b", n, led, tick, l, t);
        end
    endtask

    task automatic at(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_ch(int ch, logic [1:0] m, logic [7:0] p);
        mode[2*ch +: 2] = m;
        hp[8*ch +: 8]   = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 check_now("reset_state", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        expect_at(3,   4'hF, 4'h0, 1, 0, "idle");
        expect_at(9,   4'h0, 4'h0, 1, 0, "tick9");
        expect_at(10,  4'h0, 4'h0, 1, 1, "tick10");
        expect_at(11,  4'h0, 4'h0, 1, 0, "tick11");
        expect_at(20,  4'h0, 4'h0, 1, 1, "tick20");
        expect_at(30,  4'h0, 4'h0, 1, 1, "tick30");
        expect_at(12,  4'h1, 4'h0, 0, 0, "ch0_pre");
        expect_at(13,  4'h1, 4'h1, 0, 0, "ch0_on");
        expect_at(30,  4'h1, 4'h1, 0, 0, "ch0_hi_end");
        expect_at(31,  4'h1, 4'h0, 0, 0, "ch0_lo");
        expect_at(50,  4'h1, 4'h0, 0, 0, "ch0_lo_end");
        expect_at(51,  4'h1, 4'h1, 0, 0, "ch0_hi2");
        expect_at(71,  4'h1, 4'h0, 0, 0, "ch0_lo2");
        expect_at(22,  4'h2, 4'h0, 0, 0, "ch1_pre");
        expect_at(23,  4'h2, 4'h2, 0, 0, "ch1_on");
        expect_at(31,  4'h2, 4'h0, 0, 0, "ch1_hp0_t1");
        expect_at(41,  4'h2, 4'h2, 0, 0, "ch1_hp0_t2");
        expect_at(71,  4'h2, 4'h2, 0, 0, "ch1_hp5_hold");
        expect_at(80,  4'h2, 4'h2, 0, 0, "ch1_pre_shrink");
        expect_at(81,  4'h2, 4'h0, 0, 0, "ch1_shrink_toggle");
        expect_at(91,  4'h4, 4'h0, 0, 0, "ch2_idle");
        expect_at(92,  4'h4, 4'h4, 0, 0, "ch2_evt");
        expect_at(120, 4'h4, 4'h4, 0, 0, "ch2_stretch");
        expect_at(121, 4'h4, 4'h0, 0, 0, "ch2_expire");
        expect_at(132, 4'h4, 4'h4, 0, 0, "ch2_evt2");
        expect_at(160, 4'h4, 4'h4, 0, 0, "ch2_extend");
        expect_at(170, 4'h4, 4'h4, 0, 0, "ch2_extend_end");
        expect_at(171, 4'h4, 4'h0, 0, 0, "ch2_expire2");
        expect_at(131, 4'h8, 4'h0, 0, 0, "ch3_idle");
        expect_at(132, 4'h8, 4'h8, 0, 0, "ch3_evt");
        expect_at(160, 4'h8, 4'h8, 0, 0, "ch3_str1");
        expect_at(162, 4'h8, 4'h8, 0, 0, "ch3_reload");
        expect_at(190, 4'h8, 4'h8, 0, 0, "ch3_reload_end");
        expect_at(191, 4'h8, 4'h0, 0, 0, "ch3_expire");
        expect_at(197, 4'h8, 4'h0, 0, 0, "ch3_off_evt");
        expect_at(203, 4'h8, 4'h0, 0, 0, "ch3_off_evt2");
        expect_at(206, 4'h8, 4'h8, 0, 0, "ch3_blink_on");
        expect_at(214, 4'hF, 4'hF, 0, 0, "all_lit");
        expect_at(220, 4'hF, 4'hF, 1, 1, "pre_reset");

        at(12);  set_ch(0, 2'b10, 8'd2);
        at(22);  set_ch(1, 2'b10, 8'd0);
        at(42);  hp[15:8] = 8'd5;
        at(72);  hp[15:8] = 8'd1;
        at(82);  set_ch(2, 2'b11, 8'd0);
        at(91);  ev[2] = 1'b1;
        at(92);  ev[2] = 1'b0;
        at(122); set_ch(3, 2'b11, 8'd0);
        at(131); ev = 4'b1100;
        at(132); ev = 4'b0000;
        at(141); ev[2] = 1'b1;
        at(142); ev[2] = 1'b0;
        at(160); ev[3] = 1'b1;
        at(161); ev[3] = 1'b0;
        at(192); set_ch(3, 2'b00, 8'd0);
        at(195); ev[3] = 1'b1;
        at(205); ev[3] = 1'b0; set_ch(3, 2'b10, 8'd3);
        at(211); ev[2] = 1'b1;
        at(212); ev[2] = 1'b0;
        at(220);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset", 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        check_now("reset_hold", 4'b0000, 1'b0);
        rst_n = 1'b1;

        expect_at(1,  4'hF, 4'b1011, 1, 0, "restart");
        expect_at(9,  4'h0, 4'h0,    1, 0, "restart_tick9");
        expect_at(10, 4'hF, 4'b1011, 1, 1, "restart_tick10");
        expect_at(11, 4'hF, 4'b1001, 1, 0, "restart_c11");
        expect_at(21, 4'hF, 4'b1010, 0, 0, "restart_c21");

        at(30);
        @(negedge clk);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked (cyc %0d)", sb[i].name, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
